// File: rtl/neo_pkg.sv
// Shared defaults, FSM states and event record for the NEO spike detector.
package neo_pkg;

  localparam int NEO_N_DEF  = 16;
  localparam int NEO_M_DEF  = 32;
  localparam int NEO_AW_DEF = $clog2(NEO_M_DEF);
  localparam int NEO_SW_DEF = NEO_N_DEF + NEO_AW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    THRESH,
    DETECT,
    DONE
  } neo_state_t;

  typedef struct packed {
    logic [NEO_AW_DEF-1:0]       addr;
    logic signed [NEO_N_DEF-1:0] value;
  } neo_event_t;

  // Width of the accumulator that holds the sum of M clipped samples.
  function automatic int neo_sum_width(input int n, input int m);
    return n + $clog2(m);
  endfunction

endpackage

// File: rtl/neo_thresh_calc.sv
// Combinational adaptive threshold: mean of the clipped sum, times gain,
// saturated to the positive signed range and floored at THR_MIN.
module neo_thresh_calc
  import neo_pkg::*;
#(
  parameter int N       = NEO_N_DEF,
  parameter int M       = NEO_M_DEF,
  parameter int K_GAIN  = 4,
  parameter int THR_MIN = 16
) (
  input  logic [neo_sum_width(N, M)-1:0] sum,
  output logic signed [N-1:0]            thr
);

  localparam int AW = $clog2(M);
  localparam int PW = N + 8;
  localparam logic [PW-1:0] THR_MAX = PW'((2 ** (N - 1)) - 1);
  localparam logic [PW-1:0] FLOOR   = PW'(THR_MIN);

  logic [N-1:0]  mean;
  logic [PW-1:0] prod;
  logic [PW-1:0] capped;

  assign mean = N'(sum >> AW);
  assign prod = PW'(mean) * PW'(K_GAIN);

  always_comb begin
    capped = prod;
    if (prod > THR_MAX) begin
      capped = THR_MAX;
    end
    if (capped < FLOOR) begin
      capped = FLOOR;
    end
    thr = signed'(capped[N-1:0]);
  end

endmodule

// File: rtl/neo_spike_detector.sv
// Two-pass scan of the NEO result buffer: sum positives, derive a threshold,
// then stream one event per spike. NEO_REFRACT_EN adds a refractory window.
module neo_spike_detector
  import neo_pkg::*;
#(
  parameter int N       = NEO_N_DEF,
  parameter int M       = NEO_M_DEF,
  parameter int K_GAIN  = 4,
  parameter int THR_MIN = 16,
  parameter int REFRACT = 3
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [$clog2(M)-1:0]    raddr,
  input  logic signed [N-1:0]     rdata,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(M)-1:0]    ev_addr,
  output logic signed [N-1:0]     ev_value,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(M):0]      spike_count
);

  localparam int AW = $clog2(M);
  localparam int SW = neo_sum_width(N, M);
  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  localparam logic [AW-1:0] LAST = AW'(M - 1);

  neo_state_t state_reg, state_next;

  logic [AW-1:0]        raddr_reg;
  logic [AW-1:0]        eval_addr_reg;
  logic                 eval_valid_reg;
  logic [SW-1:0]        sum_reg;
  logic signed [N-1:0]  thr_reg;
  logic signed [N-1:0]  thr_calc;
  logic signed [N-1:0]  hold_reg;
  logic                 use_hold_reg;
  logic [RW-1:0]        refr_cnt_reg;
  logic                 ev_valid_reg;
  logic [AW-1:0]        ev_addr_reg;
  logic signed [N-1:0]  ev_value_reg;
  logic [AW:0]          count_reg;

  logic signed [N-1:0]  sample;
  logic [N-1:0]         clipped;
  logic                 eval_last;
  logic                 hit;
  logic                 stall;

  neo_thresh_calc #(
    .N       (N),
    .M       (M),
    .K_GAIN  (K_GAIN),
    .THR_MIN (THR_MIN)
  ) u_thresh (
    .sum (sum_reg),
    .thr (thr_calc)
  );

  // raddr stays put during a stall, so the stalled sample is replayed from hold_reg.
  assign sample    = use_hold_reg ? hold_reg : rdata;
  assign clipped   = rdata[N-1] ? '0 : rdata;
  assign eval_last = eval_valid_reg && (eval_addr_reg == LAST);
  assign hit       = (state_reg == DETECT) && eval_valid_reg &&
                     (refr_cnt_reg == '0) && (sample > thr_reg);
  assign stall     = hit && ev_valid_reg && !ev_ready;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SUM;
        end
      end
      SUM: begin
        busy = 1'b1;
        if (eval_last) begin
          state_next = THRESH;
        end
      end
      THRESH: begin
        busy       = 1'b1;
        state_next = DETECT;
      end
      DETECT: begin
        busy = 1'b1;
        if (eval_last && !stall) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      raddr_reg      <= '0;
      eval_addr_reg  <= '0;
      eval_valid_reg <= 1'b0;
      sum_reg        <= '0;
      thr_reg        <= '0;
      hold_reg       <= '0;
      use_hold_reg   <= 1'b0;
      refr_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sum_reg        <= '0;
            raddr_reg      <= '0;
            eval_valid_reg <= 1'b0;
            use_hold_reg   <= 1'b0;
          end
        end
        SUM: begin
          if (eval_valid_reg) begin
            sum_reg <= sum_reg + SW'(clipped);
          end
          if (eval_last) begin
            raddr_reg      <= '0;
            eval_valid_reg <= 1'b0;
          end else begin
            raddr_reg      <= raddr_reg + AW'(1);
            eval_addr_reg  <= raddr_reg;
            eval_valid_reg <= 1'b1;
          end
        end
        THRESH: begin
          thr_reg        <= thr_calc;
          raddr_reg      <= '0;
          eval_valid_reg <= 1'b0;
          use_hold_reg   <= 1'b0;
          refr_cnt_reg   <= '0;
        end
        DETECT: begin
          if (stall) begin
            hold_reg     <= sample;
            use_hold_reg <= 1'b1;
          end else begin
            use_hold_reg <= 1'b0;
`ifdef NEO_REFRACT_EN
            if (hit) begin
              refr_cnt_reg <= RW'(REFRACT);
            end else if (eval_valid_reg && (refr_cnt_reg != '0)) begin
              refr_cnt_reg <= refr_cnt_reg - RW'(1);
            end
`endif
            if (eval_last) begin
              raddr_reg      <= '0;
              eval_valid_reg <= 1'b0;
            end else begin
              raddr_reg      <= raddr_reg + AW'(1);
              eval_addr_reg  <= raddr_reg;
              eval_valid_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A new event may load in the same cycle the previous one transfers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      ev_valid_reg <= 1'b0;
      ev_addr_reg  <= '0;
      ev_value_reg <= '0;
      count_reg    <= '0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        count_reg <= '0;
      end
      if (hit && !stall) begin
        ev_valid_reg <= 1'b1;
        ev_addr_reg  <= eval_addr_reg;
        ev_value_reg <= sample;
        count_reg    <= count_reg + (AW + 1)'(1);
      end else if (ev_valid_reg && ev_ready) begin
        ev_valid_reg <= 1'b0;
      end
    end
  end

  assign raddr       = raddr_reg;
  assign ev_valid    = ev_valid_reg;
  assign ev_addr     = ev_addr_reg;
  assign ev_value    = ev_value_reg;
  assign spike_count = count_reg;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Scoreboard bench for neo_spike_detector: a reference model queues expected
// events per scan and a monitor pops them as the DUT transfers events.
module tb_neo_spike_detector;
  import neo_pkg::*;

  localparam int N       = 16;
  localparam int M       = 32;
  localparam int K_GAIN  = 4;
  localparam int THR_MIN = 16;
  localparam int REFRACT = 3;
  localparam int AW      = 5;

  logic                Clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                ev_ready;
  logic [AW-1:0]       raddr;
  logic [AW-1:0]       ev_addr;
  logic signed [N-1:0] rdata;
  logic signed [N-1:0] ev_value;
  logic                ev_valid;
  logic                busy;
  logic                done;
  logic [AW:0]         spike_count;

  logic signed [N-1:0] mem [M];

  int         checks = 0;
  int         failures = 0;
  int         exp_count;
  neo_event_t exp_q[$];
  bit         ready_rand = 1'b0;
  logic       ready_force = 1'b1;

  always #5 Clk = ~Clk;

  always @(posedge Clk) rdata <= mem[raddr];

  neo_spike_detector #(
    .N       (N),
    .M       (M),
    .K_GAIN  (K_GAIN),
    .THR_MIN (THR_MIN),
    .REFRACT (REFRACT)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .start       (start),
    .raddr       (raddr),
    .rdata       (rdata),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_addr     (ev_addr),
    .ev_value    (ev_value),
    .busy        (busy),
    .done        (done),
    .spike_count (spike_count)
  );

  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      ev_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: every transfer must match the head of the expected queue.
  initial begin
    neo_event_t e;
    forever begin
      @(negedge Clk);
      if (reset && ev_valid && ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event_unexpected actual addr=%0d value=%0d required=none", ev_addr, ev_value);
        end else begin
          e = exp_q.pop_front();
          if (ev_addr !== e.addr || ev_value !== e.value) begin
            failures++;
            $display("FAIL event actual addr=%0d value=%0d required addr=%0d value=%0d",
                     ev_addr, ev_value, e.addr, e.value);
          end else begin
            $display("EV addr=%0d value=%0d ok", ev_addr, ev_value);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model straight from the threshold and spike rules.
  task automatic model_scan();
    int sum, mean, thr, blocked;
    neo_event_t e;
    sum = 0;
    for (int i = 0; i < M; i++) begin
      if (int'(mem[i]) > 0) sum += int'(mem[i]);
    end
    mean = sum / M;
    thr  = mean * K_GAIN;
    if (thr > 32767) thr = 32767;
    if (thr < THR_MIN) thr = THR_MIN;
    blocked   = -1;
    exp_count = 0;
    for (int a = 0; a < M; a++) begin
      if (int'(mem[a]) > thr && a > blocked) begin
        e.addr  = AW'(a);
        e.value = mem[a];
        exp_q.push_back(e);
        exp_count++;
`ifdef NEO_REFRACT_EN
        blocked = a + REFRACT;
`endif
      end
    end
    $display("SCAN sum=%0d thr=%0d expected_events=%0d", sum, thr, exp_count);
  endtask

  task automatic fill(input int base, input int spike_a, input int spike_b, input int spike_c);
    for (int i = 0; i < M; i++) begin
      mem[i] = N'(base);
      if (i == spike_a || i == spike_b || i == spike_c) mem[i] = 16'sd1000;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // exp_lat = 0 skips the latency comparison (random back-pressure).
  task automatic run_scan(input int exp_lat);
    int k;
    bit seen;
    model_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 800) begin
      tick();
      k++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (exp_lat > 0) check("done_latency", k, exp_lat);
    check("spike_count", spike_count, exp_count);
    tick();
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    drain();
  endtask

  initial begin
    int k, r0, dcount;
    for (int i = 0; i < M; i++) mem[i] = '0;
    ready_force = 1'b1;
    tick();
    tick();
    check("reset_ev_valid", ev_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_raddr", raddr, 0);
    check("reset_spike_count", spike_count, 0);
    reset = 1'b1;
    tick();
    tick();

    // All zero: floor threshold, no events, nominal latency.
    fill(0, -1, -1, -1);
    run_scan(2 * M + 3);

    // Single spike at 5 over a background of 10.
    fill(10, 5, -1, -1);
    run_scan(2 * M + 3);

    // Close spikes at 5, 6, 9: refractory window decides whether 6 reports.
    fill(10, 5, 6, 9);
    run_scan(2 * M + 3);

    // Negatives clipped: only location 0 exceeds the floor.
    fill(-500, -1, -1, -1);
    mem[0] = 16'sd20;
    run_scan(2 * M + 3);

    // Boundary: value equal to the floor threshold is not a spike.
    fill(0, -1, -1, -1);
    mem[31] = 16'sd16;
    mem[30] = 16'sd17;
    run_scan(2 * M + 3);

    // Back-pressure: hold ev_ready low for 10 cycles once event 3 is valid.
    fill(10, 3, 4, -1);
    model_scan();
    ready_force = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!ev_valid && k < 200) begin
      tick();
      k++;
    end
    check("stall_ev_valid_seen", ev_valid, 1);
    r0 = int'(raddr);
    for (int i = 0; i < 10; i++) begin
      check("stall_ev_addr", ev_addr, 3);
      if (i > 0) check("stall_raddr_frozen", raddr, r0);
      tick();
      k++;
    end
    ready_force = 1'b1;
    while (!done && k < 800) begin
      tick();
      k++;
    end
    check("stall_done_latency", k, 2 * M + 3 + 10);
    check("stall_spike_count", spike_count, exp_count);
    drain();

    // Reset in the middle of DETECT aborts the scan.
    fill(10, 5, 6, 9);
    model_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < M + 8; i++) tick();
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("abort_ev_valid", ev_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_spike_count", spike_count, 0);
    tick();
    tick();
    reset  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 2 * M + 10; i++) begin
      tick();
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_idle_busy", busy, 0);
    fill(10, 5, -1, -1);
    run_scan(2 * M + 3);

    // Randomised buffers, alternating random back-pressure.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(0, 5) == 0) mem[i] = N'(int'($urandom_range(300, 30000)));
        else mem[i] = N'(int'($urandom_range(0, 400)) - 200);
      end
      ready_rand = t[0];
      run_scan(t[0] ? 0 : 2 * M + 3);
      ready_rand = 1'b0;
      tick();
      tick();
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
